spi_cmd_sequencer: RTL and testbench
====================================

// Module: spi_cmd_sequencer
// PURPOSE
//  Assembles SPI receive bytes into 17-byte command frames: 16 ASCII command characters plus 1 argument byte.
//  Decodes each frame and sequences the board resources: ADC chip-selects, green LEDs and red LEDs.
//  Sits between the SPI slave byte interface and the board pins, replacing ad-hoc per-command logic.
//  Reports per-frame completion status to the host-side status path.
// PARAMETERS
//  N_ADC    18    number of ADC chip-selects, active low
//  N_LED    35    LEDs per colour
//  CMD_LEN  16    command characters per frame, space left-padded
//  TIMEOUT  1024  idle cycles allowed between bytes inside a frame before abort
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  rst          in   1      asynchronous, active-high reset
//  rx_valid     in   1      1-cycle strobe: rx_data holds a received byte
//  rx_data      in   8      received byte
//  frame_abort  in   1      1-cycle strobe: SPI NCS deasserted
//  adc_ncs      out  N_ADC  ADC chip-selects, 0 = selected
//  gleds        out  N_LED  green LED drives, 1 = on
//  rleds        out  N_LED  red LED drives, 1 = on
//  busy         out  1      high while in EXEC
//  cmd_done     out  1      1-cycle pulse: frame finished, successfully or not
//  cmd_err      out  2      valid only with cmd_done: 0 ok, 1 unknown cmd, 2 arg out of range, 3 abort/timeout
//  rx_overrun   out  1      1-cycle pulse: byte dropped while busy
// BEHAVIOUR
//  Reset (async): adc_ncs all 1; gleds = 0; rleds = 0; busy/cmd_done/rx_overrun = 0; cmd_err = 0.
//    Also: state IDLE, byte counter = 0, command register = all spaces (0x20), timeout counter = 0.
//  FSM states: IDLE, CMD, ARG, EXEC.
//  IDLE: on rx_valid, shift the byte into the command register and go to CMD with count = 1.
//  CMD: each rx_valid shifts the register left 8 bits, new byte in the LSB. The first byte received ends up as the MSB char.
//    When count reaches CMD_LEN, go to ARG.
//  ARG: next rx_valid latches the argument byte and goes to EXEC.
//  EXEC: one cycle; decode, then return to IDLE. Outputs and cmd_done change at the edge ending EXEC.
//    Latency: 2 cycles from the arg-byte rx_valid cycle to the cmd_done cycle.
//  Commands (exact 16-char match; arg = a; ch = a/2):
//    "      adc_select"  adc_ncs = ~(1<<ch); requires ch < N_ADC.
//    "    adc_unselect"  adc_ncs[ch] = 1; requires ch < N_ADC.
//    "adc_unselect_all"  adc_ncs all 1; arg ignored.
//    "         rled_on" / "        rled_off"  rleds[a] = 1 / 0; requires a < N_LED.
//    "         gled_on" / "        gled_off"  gleds[a] = 1 / 0; requires a < N_LED.
//    "   adc_ncs_reset" / "  red_leds_reset" / "green_leds_reset"  restore that output's reset value; arg ignored.
//  No match: cmd_err = 1, outputs unchanged. Range failure: cmd_err = 2, outputs unchanged.
//  frame_abort in CMD or ARG: discard frame, go to IDLE, cmd_done with cmd_err = 3 on the next cycle.
//    frame_abort in IDLE or EXEC is ignored.
//  Timeout counter:
//    Clears on every accepted byte and in IDLE/EXEC; increments in CMD/ARG.
//    Reaching TIMEOUT-1 behaves exactly as frame_abort.
//  Simultaneous rx_valid and frame_abort: abort wins and the byte is dropped, with no rx_overrun.
//  rx_valid in EXEC: byte dropped and rx_overrun pulses the next cycle; EXEC still completes normally.
//  A new frame may start on the cycle after EXEC, in IDLE; back-to-back frames need no gap beyond EXEC.
//  Reset mid-frame: immediate return to reset values. No cmd_done is emitted.
// TESTING
//  1. "      adc_select", arg 0x07 -> 2 cycles after arg: adc_ncs = 18'h3FFF7, cmd_done = 1, cmd_err = 0.
//  2. "         gled_on" arg 34, then "         rled_on" arg 0 -> gleds = 1<<34, rleds = 1, two cmd_done pulses with err 0.
//  3. "         rled_on" arg 35 -> cmd_err = 2, rleds unchanged.
//     Frame "xxxxxxxxxxxxxxxx" with any arg -> cmd_err = 1, no output change.
//  4. 9 bytes of a command then frame_abort -> next-cycle cmd_done, cmd_err = 3.
//     A following full "adc_unselect_all" frame executes correctly.
//  5. 5 bytes then 1024 idle cycles -> cmd_done with cmd_err = 3.
//     rx_valid during EXEC -> rx_overrun pulse; rx_valid together with frame_abort -> abort, no overrun.
//  6. Assert rst at byte 12 of a frame -> adc_ncs = 18'h3FFFF, LEDs 0, no cmd_done.
//     A following full frame decodes correctly.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// Builds 17-byte SPI command frames (16 chars + arg), decodes them and drives ADC chip-selects and LEDs.
// Outputs, cmd_done and cmd_err update on the edge that ends EXEC, two cycles after the arg byte.
module spi_cmd_sequencer #(
    parameter int N_ADC   = 18,
    parameter int N_LED   = 35,
    parameter int CMD_LEN = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             frame_abort,
    output logic [N_ADC-1:0] adc_ncs,
    output logic [N_LED-1:0] gleds,
    output logic [N_LED-1:0] rleds,
    output logic             busy,
    output logic             cmd_done,
    output logic [1:0]       cmd_err,
    output logic             rx_overrun
);
    localparam int CW = $clog2(CMD_LEN + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = 8 * CMD_LEN;

    localparam logic [RW-1:0] SPACES          = {CMD_LEN{8'h20}};
    localparam logic [RW-1:0] C_ADC_SEL       = "      adc_select";
    localparam logic [RW-1:0] C_ADC_UNSEL     = "    adc_unselect";
    localparam logic [RW-1:0] C_ADC_UNSEL_ALL = "adc_unselect_all";
    localparam logic [RW-1:0] C_RLED_ON       = "         rled_on";
    localparam logic [RW-1:0] C_RLED_OFF      = "        rled_off";
    localparam logic [RW-1:0] C_GLED_ON       = "         gled_on";
    localparam logic [RW-1:0] C_GLED_OFF      = "        gled_off";
    localparam logic [RW-1:0] C_ADC_RESET     = "   adc_ncs_reset";
    localparam logic [RW-1:0] C_RLED_RESET    = "  red_leds_reset";
    localparam logic [RW-1:0] C_GLED_RESET    = "green_leds_reset";

    typedef enum logic [1:0] {IDLE, CMD, ARG, EXEC} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    cmd_q, cmd_d;
    logic [7:0]       arg_q, arg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [N_ADC-1:0] adc_q, adc_d;
    logic [N_LED-1:0] gled_q, gled_d;
    logic [N_LED-1:0] rled_q, rled_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             ovr_q, ovr_d;

    logic [6:0] ch;
    logic       ch_ok, led_ok, abort_w;

    assign ch      = arg_q[7:1];
    assign ch_ok   = int'(ch) < N_ADC;
    assign led_ok  = int'(arg_q) < N_LED;
    // An inter-byte stall that runs out the timer is handled exactly like NCS going high.
    assign abort_w = frame_abort || (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        cnt_d   = cnt_q;
        tmo_d   = '0;
        adc_d   = adc_q;
        gled_d  = gled_q;
        rled_d  = rled_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid && !frame_abort) begin
                    cmd_d   = {cmd_q[RW-9:0], rx_data};
                    cnt_d   = CW'(1);
                    state_d = CMD;
                end
            end
            CMD, ARG: begin
                tmo_d = tmo_q + TW'(1);
                if (abort_w) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 2'd3;
                end else if (rx_valid) begin
                    tmo_d = '0;
                    if (state_q == CMD) begin
                        cmd_d = {cmd_q[RW-9:0], rx_data};
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q + CW'(1) == CW'(CMD_LEN)) begin
                            state_d = ARG;
                        end
                    end else begin
                        arg_d   = rx_data;
                        cnt_d   = '0;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = 2'd0;
                ovr_d   = rx_valid && !frame_abort;
                case (cmd_q)
                    C_ADC_SEL:       if (ch_ok)  adc_d  = ~(N_ADC'(1) << ch);               else err_d = 2'd2;
                    C_ADC_UNSEL:     if (ch_ok)  adc_d  = adc_q | (N_ADC'(1) << ch);        else err_d = 2'd2;
                    C_ADC_UNSEL_ALL:             adc_d  = '1;
                    C_RLED_ON:       if (led_ok) rled_d = rled_q | (N_LED'(1) << arg_q);    else err_d = 2'd2;
                    C_RLED_OFF:      if (led_ok) rled_d = rled_q & ~(N_LED'(1) << arg_q);   else err_d = 2'd2;
                    C_GLED_ON:       if (led_ok) gled_d = gled_q | (N_LED'(1) << arg_q);    else err_d = 2'd2;
                    C_GLED_OFF:      if (led_ok) gled_d = gled_q & ~(N_LED'(1) << arg_q);   else err_d = 2'd2;
                    C_ADC_RESET:                 adc_d  = '1;
                    C_RLED_RESET:                rled_d = '0;
                    C_GLED_RESET:                gled_d = '0;
                    default:                     err_d  = 2'd1;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= SPACES;
            arg_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            adc_q   <= '1;
            gled_q  <= '0;
            rled_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 2'd0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            adc_q   <= adc_d;
            gled_q  <= gled_d;
            rled_q  <= rled_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign adc_ncs    = adc_q;
    assign gleds      = gled_q;
    assign rleds      = rled_q;
    assign busy       = (state_q == EXEC);
    assign cmd_done   = done_q;
    assign cmd_err    = err_q;
    assign rx_overrun = ovr_q;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: frames push hand-computed results, a monitor checks each cmd_done.
module tb_spi_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        frame_abort = 1'b0;
    logic [17:0] adc_ncs;
    logic [34:0] gleds, rleds;
    logic        busy, cmd_done, rx_overrun;
    logic [1:0]  cmd_err;

    spi_cmd_sequencer dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .frame_abort(frame_abort),
        .adc_ncs(adc_ncs), .gleds(gleds), .rleds(rleds), .busy(busy),
        .cmd_done(cmd_done), .cmd_err(cmd_err), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] ADC_SEL       = "      adc_select";
    localparam logic [127:0] ADC_UNSEL     = "    adc_unselect";
    localparam logic [127:0] ADC_UNSEL_ALL = "adc_unselect_all";
    localparam logic [127:0] RLED_ON       = "         rled_on";
    localparam logic [127:0] GLED_ON       = "         gled_on";
    localparam logic [127:0] GLED_OFF      = "        gled_off";
    localparam logic [127:0] ADC_RESET     = "   adc_ncs_reset";
    localparam logic [127:0] RLED_RESET    = "  red_leds_reset";
    localparam logic [127:0] GLED_RESET    = "green_leds_reset";
    localparam logic [127:0] BOGUS         = "xxxxxxxxxxxxxxxx";

    typedef struct {
        string       name;
        logic [1:0]  err;
        logic [17:0] adc;
        logic [34:0] g;
        logic [34:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   ovr_exp = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every cmd_done / rx_overrun pulse must match a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cmd_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_cmd_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_err"}, 64'(cmd_err), 64'(e.err));
                        chk({e.name, "_adc"}, 64'(adc_ncs), 64'(e.adc));
                        chk({e.name, "_gled"}, 64'(gleds), 64'(e.g));
                        chk({e.name, "_rled"}, 64'(rleds), 64'(e.r));
                    end
                end
                if (rx_overrun) begin
                    chk("rx_overrun_expected", 64'(ovr_exp > 0), 64'd1);
                    if (ovr_exp > 0) ovr_exp--;
                end
            end
        end
    end

    task automatic push(input string name, input logic [1:0] err, input logic [17:0] adc,
                        input logic [34:0] g, input logic [34:0] r);
        exp_t e;
        e.name = name; e.err = err; e.adc = adc; e.g = g; e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_partial(input logic [127:0] cmd, input int n);
        for (int i = 0; i < n; i++) send_byte(cmd[(15 - i) * 8 +: 8]);
    endtask

    // Sends a whole frame, then spends the EXEC cycle (optionally with a stray byte in it).
    task automatic send_frame(input string name, input logic [127:0] cmd, input logic [7:0] arg,
                              input logic [1:0] err, input logic [17:0] adc,
                              input logic [34:0] g, input logic [34:0] r, input bit ovr);
        push(name, err, adc, g, r);
        send_partial(cmd, 16);
        send_byte(arg);
        if (ovr) begin
            rx_valid = 1'b1;
            rx_data  = 8'h41;
            ovr_exp++;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_adc", 64'(adc_ncs), 64'h3FFFF);
        chk("reset_gled", 64'(gleds), 64'd0);
        chk("reset_rled", 64'(rleds), 64'd0);
        chk("reset_flags", {61'd0, busy, cmd_done, rx_overrun}, 64'd0);
        chk("reset_err", 64'(cmd_err), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency: cmd_done visible in the cycle after EXEC, and only for one cycle.
        send_frame("adc_sel7", ADC_SEL, 8'h07, 2'd0, 18'h3FFF7, 35'd0, 35'd0, 1'b0);
        chk("latency_done", 64'(cmd_done), 64'd1);
        @(posedge clk); #1;
        chk("done_pulse", 64'(cmd_done), 64'd0);

        send_frame("gled34", GLED_ON, 8'd34, 2'd0, 18'h3FFF7, 35'h4_0000_0000, 35'd0, 1'b0);
        send_frame("rled0", RLED_ON, 8'd0, 2'd0, 18'h3FFF7, 35'h4_0000_0000, 35'd1, 1'b0);
        send_frame("rled35", RLED_ON, 8'd35, 2'd2, 18'h3FFF7, 35'h4_0000_0000, 35'd1, 1'b0);
        send_frame("bogus", BOGUS, 8'd5, 2'd1, 18'h3FFF7, 35'h4_0000_0000, 35'd1, 1'b0);
        send_frame("adc_sel17", ADC_SEL, 8'h23, 2'd0, 18'h1FFFF, 35'h4_0000_0000, 35'd1, 1'b0);
        send_frame("adc_sel18", ADC_SEL, 8'h24, 2'd2, 18'h1FFFF, 35'h4_0000_0000, 35'd1, 1'b0);
        send_frame("adc_unsel17", ADC_UNSEL, 8'h23, 2'd0, 18'h3FFFF, 35'h4_0000_0000, 35'd1, 1'b0);
        send_frame("adc_sel0", ADC_SEL, 8'h00, 2'd0, 18'h3FFFE, 35'h4_0000_0000, 35'd1, 1'b0);

        // Explicit abort after 9 bytes.
        send_partial(ADC_UNSEL, 9);
        push("abort9", 2'd3, 18'h3FFFE, 35'h4_0000_0000, 35'd1);
        frame_abort = 1'b1;
        @(posedge clk); #1;
        frame_abort = 1'b0;
        chk("abort_next_cycle", 64'(cmd_done), 64'd1);
        send_frame("unsel_all", ADC_UNSEL_ALL, 8'h55, 2'd0, 18'h3FFFF, 35'h4_0000_0000, 35'd1, 1'b0);

        // Inter-byte timeout.
        send_partial(GLED_OFF, 5);
        push("timeout", 2'd3, 18'h3FFFF, 35'h4_0000_0000, 35'd1);
        repeat (1000) @(posedge clk);
        #1;
        chk("timeout_not_early", 64'(exp_q.size()), 64'd1);
        drain("timeout", 100);

        // Stray byte during EXEC is dropped and flagged; the next frame is unaffected.
        send_frame("gled_off34", GLED_OFF, 8'd34, 2'd0, 18'h3FFFF, 35'd0, 35'd1, 1'b1);
        send_frame("rled3", RLED_ON, 8'd3, 2'd0, 18'h3FFFF, 35'd0, 35'd9, 1'b0);

        // Byte coinciding with abort: abort wins, no overrun.
        send_partial(RLED_RESET, 3);
        push("abort_with_byte", 2'd3, 18'h3FFFF, 35'd0, 35'd9);
        rx_valid = 1'b1; rx_data = 8'h61; frame_abort = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; frame_abort = 1'b0;

        send_frame("rled_reset", RLED_RESET, 8'hFF, 2'd0, 18'h3FFFF, 35'd0, 35'd0, 1'b0);
        send_frame("gled0", GLED_ON, 8'd0, 2'd0, 18'h3FFFF, 35'd1, 35'd0, 1'b0);
        send_frame("adc_sel1", ADC_SEL, 8'h02, 2'd0, 18'h3FFFD, 35'd1, 35'd0, 1'b0);
        drain("pre_reset", 20);

        // Reset at byte 12 of a frame.
        send_partial(ADC_RESET, 11);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_adc", 64'(adc_ncs), 64'h3FFFF);
        chk("midreset_gled", 64'(gleds), 64'd0);
        chk("midreset_rled", 64'(rleds), 64'd0);
        chk("midreset_done", 64'(cmd_done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        send_frame("post_reset_gled7", GLED_ON, 8'd7, 2'd0, 18'h3FFFF, 35'h80, 35'd0, 1'b0);
        send_frame("adc_sel2", ADC_SEL, 8'h04, 2'd0, 18'h3FFFB, 35'h80, 35'd0, 1'b0);
        send_frame("adc_reset", ADC_RESET, 8'h00, 2'd0, 18'h3FFFF, 35'h80, 35'd0, 1'b0);
        send_frame("gled_reset", GLED_RESET, 8'h09, 2'd0, 18'h3FFFF, 35'd0, 35'd0, 1'b0);

        drain("final", 20);
        repeat (3) @(posedge clk);
        #1;
        chk("overruns_seen", 64'(ovr_exp), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
